// File: rtl/sdm_pkg.sv
// Shared constants and helpers for the sigma-delta acquisition chain stages.
package sdm_pkg;

  localparam int unsigned SDM_WIDTH = 16;
  localparam int unsigned SDM_DR = 256;
  localparam logic [SDM_WIDTH-1:0] SDM_GAIN_ONE = 16'h8000;
  localparam logic signed [SDM_WIDTH-1:0] SDM_SAT_MAX = 16'sh7FFF;
  localparam logic signed [SDM_WIDTH-1:0] SDM_SAT_MIN = 16'sh8000;

  // Clamp a wide signed intermediate into the signed output word range.
  function automatic logic signed [SDM_WIDTH-1:0] sdm_saturate(
    input logic signed [2*SDM_WIDTH:0] v
  );
    logic signed [2*SDM_WIDTH:0] hi;
    logic signed [2*SDM_WIDTH:0] lo;
    hi = {{(SDM_WIDTH+1){SDM_SAT_MAX[SDM_WIDTH-1]}}, SDM_SAT_MAX};
    lo = {{(SDM_WIDTH+1){SDM_SAT_MIN[SDM_WIDTH-1]}}, SDM_SAT_MIN};
    if (v > hi) begin
      return SDM_SAT_MAX;
    end else if (v < lo) begin
      return SDM_SAT_MIN;
    end
    return v[SDM_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/sdm_word_clkgen.sv
// Divides the modulator clock into the decimator word clock and marks the
// mid-period point at which the decimator word is safe to capture.
module sdm_word_clkgen #(
  parameter int unsigned DR = 256
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic word_clk_o,
  output logic capture_o
);

  localparam int unsigned CntW = $clog2(DR);
  localparam logic [CntW-1:0] Half = CntW'(DR / 2);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            word_clk_q, word_clk_d;

  always_comb begin
    cnt_d      = cnt_q + CntW'(1);
    // High while the next count lies in the lower half of the period.
    word_clk_d = ~cnt_d[CntW-1];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q      <= '0;
      word_clk_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      word_clk_q <= word_clk_d;
    end
  end

  assign word_clk_o = word_clk_q;
  assign capture_o  = (cnt_q == Half);

endmodule

// File: rtl/sinc3_word_post.sv
// Post-decimator stage: word capture, settle discard, offset/gain calibration
// with saturation and a valid/ready output with overrun accounting.
module sinc3_word_post
  import sdm_pkg::*;
#(
  parameter int unsigned DR           = SDM_DR,
  parameter int unsigned WIDTH        = SDM_WIDTH,
  parameter int unsigned SETTLE_WORDS = 4,
  parameter int unsigned DROP_W       = 8
) (
  input  logic                    mclkin,
  input  logic                    rst_n,
  output logic                    word_clk,
  input  logic [WIDTH-1:0]        filt_data,
  input  logic [WIDTH-1:0]        cal_offset,
  input  logic [WIDTH-1:0]        cal_gain,
  output logic signed [WIDTH-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overrun,
  output logic [DROP_W-1:0]       drop_cnt,
  output logic                    settled
);

  localparam int unsigned SetW     = $clog2(SETTLE_WORDS + 1);
  localparam int unsigned ProdW    = 2 * WIDTH + 1;
  localparam int unsigned GainFrac = $clog2(SDM_GAIN_ONE);

  logic capture;

  sdm_word_clkgen #(
    .DR (DR)
  ) u_clkgen (
    .clk_i      (mclkin),
    .rst_ni     (rst_n),
    .word_clk_o (word_clk),
    .capture_o  (capture)
  );

  logic [SetW-1:0]         settle_cnt_q, settle_cnt_d;
  logic                    settled_q, settled_d;
  logic                    cap_vld_q, cap_vld_d;
  logic [WIDTH-1:0]        cap_data_q, cap_data_d;
  logic [WIDTH-1:0]        cap_off_q, cap_off_d;
  logic [WIDTH-1:0]        cap_gain_q, cap_gain_d;
  logic                    s1_vld_q, s1_vld_d;
  logic signed [WIDTH:0]   s1_diff_q, s1_diff_d;
  logic [WIDTH-1:0]        s1_gain_q, s1_gain_d;
  logic                    s2_vld_q, s2_vld_d;
  logic signed [ProdW-1:0] s2_prod_q, s2_prod_d;
  logic signed [WIDTH-1:0] out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;
  logic                    overrun_q, overrun_d;
  logic [DROP_W-1:0]       drop_cnt_q, drop_cnt_d;

  always_comb begin
    settle_cnt_d = settle_cnt_q;
    settled_d    = settled_q;
    cap_vld_d    = 1'b0;
    cap_data_d   = cap_data_q;
    cap_off_d    = cap_off_q;
    cap_gain_d   = cap_gain_q;
    if (capture) begin
      // The first words out of the sinc3 are pipeline-fill garbage.
      if (settle_cnt_q < SetW'(SETTLE_WORDS)) begin
        settle_cnt_d = settle_cnt_q + SetW'(1);
        if (settle_cnt_q == SetW'(SETTLE_WORDS - 1)) begin
          settled_d = 1'b1;
        end
      end else begin
        cap_vld_d  = 1'b1;
        cap_data_d = filt_data;
        cap_off_d  = cal_offset;
        cap_gain_d = cal_gain;
      end
    end

    s1_vld_d  = cap_vld_q;
    s1_diff_d = $signed({1'b0, cap_data_q}) - $signed({1'b0, cap_off_q});
    s1_gain_d = cap_gain_q;

    s2_vld_d  = s1_vld_q;
    s2_prod_d = $signed({{WIDTH{s1_diff_q[WIDTH]}}, s1_diff_q})
              * $signed({{(WIDTH+1){1'b0}}, s1_gain_q});

    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
    drop_cnt_d  = drop_cnt_q;
    if (s2_vld_q) begin
      out_data_d  = sdm_saturate(s2_prod_q >>> GainFrac);
      out_valid_d = 1'b1;
      // A landing result that coincides with a transfer is not a drop.
      if (out_valid_q && !out_ready) begin
        overrun_d = 1'b1;
        if (drop_cnt_q != '1) begin
          drop_cnt_d = drop_cnt_q + DROP_W'(1);
        end
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge mclkin or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt_q <= '0;
      settled_q    <= 1'b0;
      cap_vld_q    <= 1'b0;
      cap_data_q   <= '0;
      cap_off_q    <= '0;
      cap_gain_q   <= '0;
      s1_vld_q     <= 1'b0;
      s1_diff_q    <= '0;
      s1_gain_q    <= '0;
      s2_vld_q     <= 1'b0;
      s2_prod_q    <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      overrun_q    <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      settle_cnt_q <= settle_cnt_d;
      settled_q    <= settled_d;
      cap_vld_q    <= cap_vld_d;
      cap_data_q   <= cap_data_d;
      cap_off_q    <= cap_off_d;
      cap_gain_q   <= cap_gain_d;
      s1_vld_q     <= s1_vld_d;
      s1_diff_q    <= s1_diff_d;
      s1_gain_q    <= s1_gain_d;
      s2_vld_q     <= s2_vld_d;
      s2_prod_q    <= s2_prod_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      overrun_q    <= overrun_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;
  assign drop_cnt  = drop_cnt_q;
  assign settled   = settled_q;

endmodule

// File: tb/tb_sinc3_word_post.sv
// Randomized self-checking bench for sinc3_word_post against a cycle-indexed
// behavioural model of word timing, settling, calibration and handshake.
module tb_sinc3_word_post;

  localparam int DR     = 256;
  localparam int HALF   = DR / 2;
  localparam int SETTLE = 4;

  logic        mclkin = 1'b0;
  logic        rst_n;
  logic        word_clk;
  logic [15:0] filt_data;
  logic [15:0] cal_offset;
  logic [15:0] cal_gain;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        overrun;
  logic [7:0]  drop_cnt;
  logic        settled;

  sinc3_word_post #(
    .DR           (DR),
    .WIDTH        (16),
    .SETTLE_WORDS (SETTLE),
    .DROP_W       (8)
  ) dut (
    .mclkin     (mclkin),
    .rst_n      (rst_n),
    .word_clk   (word_clk),
    .filt_data  (filt_data),
    .cal_offset (cal_offset),
    .cal_gain   (cal_gain),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overrun    (overrun),
    .drop_cnt   (drop_cnt),
    .settled    (settled)
  );

  always #5 mclkin = ~mclkin;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: n counts rising edges since reset release.
  int          n;
  bit          m_vld, m_ovr, m_settled;
  logic [15:0] m_data;
  int          m_drop, m_settle;
  int          land_q[$];
  logic [15:0] val_q[$];

  function automatic logic [15:0] ref_cal(input int f, input int o, input int g);
    longint d, p, q;
    d = longint'(f) - longint'(o);
    p = d * longint'(g);
    q = p >>> 15;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return q[15:0];
  endfunction

  task automatic model_clear();
    n = 0; m_vld = 0; m_ovr = 0; m_settled = 0; m_data = '0; m_drop = 0; m_settle = 0;
    land_q.delete();
    val_q.delete();
  endtask

  task automatic check_outputs();
    check("word_clk", word_clk, (n == 0) ? 0 : (((n % DR) < HALF) ? 1 : 0));
    check("out_valid", out_valid, m_vld);
    check("out_data", out_data, m_data);
    check("overrun", overrun, m_ovr);
    check("drop_cnt", drop_cnt, m_drop);
    check("settled", settled, m_settled);
  endtask

  task automatic tick();
    bit          has;
    logic [15:0] v;
    @(posedge mclkin);
    n++;
    has = 0;
    v = '0;
    if (land_q.size() > 0 && land_q[0] == n) begin
      has = 1;
      v = val_q[0];
      void'(land_q.pop_front());
      void'(val_q.pop_front());
    end
    if (has) begin
      if (m_vld && !out_ready) begin
        m_ovr = 1;
        if (m_drop < 255) m_drop++;
      end
      m_vld = 1;
      m_data = v;
    end else if (m_vld && out_ready) begin
      m_vld = 0;
    end
    if ((n % DR) == HALF + 1) begin
      if (m_settle < SETTLE) begin
        m_settle++;
        if (m_settle == SETTLE) m_settled = 1;
      end else begin
        land_q.push_back(n + 3);
        val_q.push_back(ref_cal(int'(filt_data), int'(cal_offset), int'(cal_gain)));
      end
    end
    #1;
    check_outputs();
  endtask

  task automatic run(input int k);
    repeat (k) tick();
  endtask

  task automatic wait_phase(input int p);
    for (int i = 0; i < DR && (n % DR) != p; i++) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_clear();
    check_outputs();
    repeat (2) @(posedge mclkin);
    #1;
    rst_n = 1'b1;
    n = 0;
  endtask

  logic [15:0] vec_f[5]   = '{16'h0100, 16'h0100, 16'hFFFF, 16'h0000, 16'h4321};
  logic [15:0] vec_o[5]   = '{16'h0200, 16'h0200, 16'h0000, 16'hFFFF, 16'h0021};
  logic [15:0] vec_g[5]   = '{16'h8000, 16'h4000, 16'hFFFF, 16'hFFFF, 16'h0000};
  logic [15:0] vec_exp[5] = '{16'hFF00, 16'hFF80, 16'h7FFF, 16'h8000, 16'h0000};

  initial begin
    rst_n = 1'b1;
    filt_data = 16'h1234;
    cal_offset = 16'h0000;
    cal_gain = 16'h8000;
    out_ready = 1'b1;
    #2;
    do_reset();

    // Four discards, fifth capture at edge 129 + 4*DR lands three edges later.
    run(HALF + 1 + SETTLE * DR + 2);
    check("latency_early_valid", out_valid, 0);
    tick();
    check("first_sample_valid", out_valid, 1);
    check("first_sample_data", out_data, 16'h1234);
    check("first_sample_settled", settled, 1);

    for (int i = 0; i < 5; i++) begin
      filt_data = vec_f[i];
      cal_offset = vec_o[i];
      cal_gain = vec_g[i];
      run(2 * DR);
      check("cal_vector", out_data, vec_exp[i]);
    end

    cal_offset = 16'h0010;
    cal_gain = 16'h8000;
    wait_phase(200);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      filt_data = 16'($urandom);
      run(DR);
    end
    check("ovr_valid", out_valid, 1);
    check("ovr_newest", out_data, ref_cal(int'(filt_data), 16, 32768));
    check("ovr_flag", overrun, 1);
    check("ovr_drop_cnt", drop_cnt, 2);
    out_ready = 1'b1;
    tick();
    check("ovr_consumed_valid", out_valid, 0);
    check("ovr_sticky", overrun, 1);

    for (int w = 0; w < 40; w++) begin
      wait_phase(1);
      filt_data = 16'($urandom);
      cal_offset = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
      cal_gain = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      for (int c = 0; c < DR; c++) begin
        out_ready = ($urandom_range(0, 3) != 0);
        tick();
      end
    end

    // Reset one edge after a capture, with a sample still in flight.
    out_ready = 1'b1;
    filt_data = 16'h0ABC;
    cal_offset = 16'h0000;
    cal_gain = 16'h8000;
    wait_phase(HALF + 1);
    tick();
    do_reset();
    run(SETTLE * DR + HALF);
    check("restart_settled", settled, 1);
    check("restart_no_sample", out_valid, 0);
    run(4);
    check("restart_sample_valid", out_valid, 1);
    check("restart_sample_data", out_data, 16'h0ABC);

    // Reset while word_clk is high must drop it at once.
    wait_phase(50);
    rst_n = 1'b0;
    #1;
    check("async_wclk_drop", word_clk, 0);
    check("async_valid_drop", out_valid, 0);
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
